// File: rtl/gate_tester_pkg.sv
// Shared types and golden model for the two-input gate tester.
package gate_tester_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_NOR  = 2'd2,
        OP_NAND = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int NUM_VECTORS = 4;

    // Golden output of the selected operation for inputs (a, b).
    function automatic logic expected(input op_t op, input logic a, input logic b);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_NOR:  return ~(a | b);
            OP_NAND: return ~(a & b);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/gate_tester.sv
// Stimulus/response engine: walks a two-input gate through all four input
// vectors, samples its output after a settle delay and checks it against
// the golden truth table of the latched operation.
module gate_tester
    import gate_tester_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic [1:0] i_op,
    output logic       o_a,
    output logic       o_b,
    input  logic       i_c,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_pass,
    output logic [3:0] o_fail_mask,
    output logic [1:0] o_vec_idx
);

    // A zero settle time would sample on the same cycle the vector changes.
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("gate_tester: SETTLE_CYCLES must be at least 1");
    end

    localparam int               CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [1:0]       VEC_LAST = 2'(NUM_VECTORS - 1);

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_d;
    logic [3:0]       mask_d;
    logic             pass_d;
    logic             miss;
    logic             drive;

    // Only the SAMPLE cycle looks at the gate output, so settle glitches never count.
    assign miss  = (i_c != expected(op_q, o_vec_idx[1], o_vec_idx[0]));
    assign drive = (state_d == SETTLE) || (state_d == SAMPLE);

    // Next-state and next-result logic; vector index and mask live in the output registers.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        idx_d   = o_vec_idx;
        mask_d  = o_fail_mask;
        pass_d  = o_pass;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    op_d    = op_t'(i_op);
                    cnt_d   = '0;
                    idx_d   = 2'd0;
                    mask_d  = 4'd0;
                    pass_d  = 1'b0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (miss) begin
                    mask_d[o_vec_idx] = 1'b1;
                end
                cnt_d = '0;
                if (o_vec_idx == VEC_LAST) begin
                    // Verdict includes this final compare and is visible alongside o_done.
                    pass_d  = (mask_d == 4'd0);
                    state_d = DONE;
                end else begin
                    idx_d   = o_vec_idx + 2'd1;
                    state_d = SETTLE;
                end
            end
            DONE: begin
                idx_d   = 2'd0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched op and all outputs registered; gate drives are zero outside a test.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            op_q        <= OP_AND;
            cnt_q       <= '0;
            o_vec_idx   <= 2'd0;
            o_fail_mask <= 4'd0;
            o_pass      <= 1'b0;
            o_a         <= 1'b0;
            o_b         <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            o_vec_idx   <= idx_d;
            o_fail_mask <= mask_d;
            o_pass      <= pass_d;
            o_a         <= drive & idx_d[1];
            o_b         <= drive & idx_d[0];
            o_busy      <= (state_d != IDLE);
            o_done      <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_gate_tester.sv
// Bench for gate_tester: two instances (settle 2 and settle 1) face a
// bench-modelled gate described by a truth table; a timeline model predicts
// every output on every cycle, and directed tests pin latency and results.
module tb_gate_tester;

    localparam int S0 = 2;
    localparam int S1 = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic [1:0] i_op = 2'd0;
    logic [3:0] g_tt = 4'b1000;
    bit         chk_en = 1'b0;

    logic       a0, b0, c0, busy0, done0, pass0;
    logic [3:0] mask0;
    logic [1:0] idx0;
    logic       a1, b1, c1, busy1, done1, pass1;
    logic [3:0] mask1;
    logic [1:0] idx1;

    int n_chk = 0;
    int n_fail = 0;

    int         m_t    [2];
    logic [3:0] m_fin  [2];
    bit         m_have [2];

    always #5 clk = ~clk;

    // Gate under test: bit {a,b} of the truth table.
    assign c0 = g_tt[{a0, b0}];
    assign c1 = g_tt[{a1, b1}];

    gate_tester #(.SETTLE_CYCLES(S0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_op(i_op),
        .o_a(a0), .o_b(b0), .i_c(c0), .o_busy(busy0), .o_done(done0),
        .o_pass(pass0), .o_fail_mask(mask0), .o_vec_idx(idx0)
    );

    gate_tester #(.SETTLE_CYCLES(S1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_op(i_op),
        .o_a(a1), .o_b(b1), .i_c(c1), .o_busy(busy1), .o_done(done1),
        .o_pass(pass1), .o_fail_mask(mask1), .o_vec_idx(idx1)
    );

    // Golden truth tables, bit k = output for input vector k = {a,b}.
    function automatic logic [3:0] gold_tt(input logic [1:0] op);
        case (op)
            2'd0:    return 4'b1000;
            2'd1:    return 4'b1110;
            2'd2:    return 4'b0001;
            default: return 4'b0111;
        endcase
    endfunction

    function automatic int dur(input int s);
        return 4 * (s + 1) + 1;
    endfunction

    // Expected {busy,done,a,b,idx,pass,mask} at test cycle t (0 = idle).
    function automatic logic [10:0] exp_out(input int t, input int s, input logic [3:0] fin, input bit have);
        int         k;
        logic [1:0] kv;
        logic [3:0] part;
        if (t == 0)
            return {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, have && (fin == 4'd0), have ? fin : 4'd0};
        if (t == dur(s))
            return {1'b1, 1'b1, 1'b0, 1'b0, 2'd3, fin == 4'd0, fin};
        k = (t - 1) / (s + 1);
        kv = k[1:0];
        part = 4'd0;
        for (int j = 0; j < 4; j++)
            if ((j + 1) * (s + 1) < t) part[j] = fin[j];
        return {1'b1, 1'b0, kv[1], kv[0], kv, 1'b0, part};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Timeline model: a test runs for dur(s) cycles after an accepted start.
    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_t[d]    <= 0;
                m_have[d] <= 1'b0;
                m_fin[d]  <= 4'd0;
            end else if (m_t[d] == 0) begin
                if (i_start) begin
                    m_t[d]    <= 1;
                    m_have[d] <= 1'b0;
                    m_fin[d]  <= g_tt ^ gold_tt(i_op);
                end
            end else if (m_t[d] == dur(d == 0 ? S0 : S1)) begin
                m_t[d]    <= 0;
                m_have[d] <= 1'b1;
            end else begin
                m_t[d] <= m_t[d] + 1;
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cycle_s2", {busy0, done0, a0, b0, idx0, pass0, mask0}, exp_out(m_t[0], S0, m_fin[0], m_have[0]));
            chk("cycle_s1", {busy1, done1, a1, b1, idx1, pass1, mask1}, exp_out(m_t[1], S1, m_fin[1], m_have[1]));
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy0 || busy1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", {busy0, busy1}, 0);
        @(negedge clk);
    endtask

    // One pulsed test; pins latency, mask and verdict of the selected instance.
    task automatic run(input string nm, input logic [1:0] op, input int sel,
                       input int exp_lat, input logic [3:0] exp_mask, input logic exp_pass);
        int n;
        bit seen;
        @(negedge clk);
        #1;
        i_start = 1'b1;
        i_op = op;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 60) begin
            @(negedge clk);
            n++;
            seen = (sel == 0) ? done0 : done1;
            #1;
            i_start = 1'b0;
        end
        chk({nm, "_latency"}, n, exp_lat);
        chk({nm, "_mask"}, (sel == 0) ? mask0 : mask1, exp_mask);
        chk({nm, "_pass"}, (sel == 0) ? pass0 : pass1, exp_pass);
        wait_idle();
    endtask

    initial begin
        int nd, first, second;
        @(negedge clk);
        chk_en = 1'b1;
        chk("reset_state", {busy0, done0, a0, b0, idx0, pass0, mask0}, 11'd0);
        #3;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        g_tt = 4'b1000;
        run("and_as_and", 2'd0, 0, 13, 4'b0000, 1'b1);
        run("and_as_or", 2'd1, 0, 13, 4'b0110, 1'b0);
        g_tt = 4'b0001;
        run("nor_as_and", 2'd0, 0, 13, 4'b1001, 1'b0);
        run("nor_as_nor", 2'd2, 0, 13, 4'b0000, 1'b1);
        g_tt = 4'b1111;
        run("one_as_nand", 2'd3, 0, 13, 4'b1000, 1'b0);
        run("one_as_nand_s1", 2'd3, 1, 9, 4'b1000, 1'b0);

        // Start re-pulsed while busy and op toggled mid-test.
        g_tt = 4'b1000;
        @(negedge clk);
        #1;
        i_start = 1'b1;
        i_op = 2'd0;
        nd = 0;
        first = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (done0) begin
                nd++;
                if (first == 0) first = c;
            end
            #1;
            i_start = (c == 4) || (c == 12);
            i_op = (c % 2 == 1) ? 2'd1 : 2'd0;
        end
        i_start = 1'b0;
        i_op = 2'd0;
        chk("repulse_done_count", nd, 1);
        chk("repulse_done_cycle", first, 13);
        chk("repulse_mask", mask0, 4'b0000);
        chk("repulse_pass", pass0, 1'b1);
        wait_idle();

        // Start held high: back-to-back tests.
        @(negedge clk);
        #1;
        i_start = 1'b1;
        nd = 0;
        first = 0;
        second = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (done0) begin
                nd++;
                if (nd == 1) first = c;
                if (nd == 2) second = c;
            end
        end
        #1;
        i_start = 1'b0;
        chk("held_done_count", nd, 2);
        chk("held_first_done", first, 13);
        chk("held_done_period", second - first, 14);
        wait_idle();

        // Asynchronous reset in the middle of a test.
        @(negedge clk);
        #1;
        i_start = 1'b1;
        repeat (6) begin
            @(negedge clk);
            #1;
            i_start = 1'b0;
        end
        chk("pre_reset_busy", busy0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_s2", {busy0, done0, a0, b0, idx0, pass0, mask0}, 11'd0);
        chk("async_reset_s1", {busy1, done1, a1, b1, idx1, pass1, mask1}, 11'd0);
        nd = 0;
        repeat (2) begin
            @(negedge clk);
            if (done0 || done1) nd++;
        end
        #3;
        rst_n = 1'b1;
        repeat (16) begin
            @(negedge clk);
            if (done0 || done1) nd++;
        end
        chk("reset_no_done", nd, 0);
        chk("reset_idle_result", {pass0, mask0}, 5'd0);

        g_tt = 4'b0001;
        run("after_reset", 2'd2, 0, 13, 4'b0000, 1'b1);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gate_tester.md
Name: gate_tester

Overview:
- Self-checking stimulus/response engine for two-input gates.
- Drives the gate inputs through all four input combinations, samples the gate output after a settle delay, and compares each sample against a golden truth table for the selected operation.
- Reports pass/fail plus a per-vector failure mask.
- Sits opposite the gate under test: its outputs feed the gate inputs, and the gate output returns to its input.

Parameters:
- SETTLE_CYCLES, default 2: clock cycles a vector is held before sampling. Minimum 1; 0 is rejected by an elaboration-time assertion.

Ports:
- i_clk  input  1  system clock, rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_start  input  1  start request; accepted only in IDLE
- i_op  input  2  golden operation select: 0 AND, 1 OR, 2 NOR, 3 NAND
- o_a  output  1  gate input A drive
- o_b  output  1  gate input B drive
- i_c  input  1  gate output under test
- o_busy  output  1  high from the accepted start until the DONE cycle, inclusive
- o_done  output  1  one-cycle completion pulse
- o_pass  output  1  result of the last completed test, held until next start
- o_fail_mask  output  4  bit k set means vector k mismatched; held until next start
- o_vec_idx  output  2  index of the vector currently driven

Behaviour:
- Interface: one clock, i_clk. Reset i_rst_n is asynchronous and active-low.
- Reset values: state IDLE; o_a, o_b, o_busy, o_done, o_pass = 0; o_fail_mask = 0; o_vec_idx = 0; settle counter = 0.
- Vector order: idx 0..3 maps to (a,b) = 00, 01, 10, 11, with o_a = idx[1] and o_b = idx[0], both registered.
- o_a and o_b are forced to 0 in IDLE and DONE.

State machine (IDLE, SETTLE, SAMPLE, DONE):
- IDLE, i_start=1:
  - latch i_op into op_q; clear idx, counter, o_fail_mask and o_pass;
  - o_busy <= 1; go to SETTLE.
  - i_start=0: stay in IDLE.
- SETTLE:
  - drive vector idx; counter increments each cycle;
  - when counter == SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE:
  - vector is still driven; compare i_c with expected(op_q, idx);
  - on mismatch, set o_fail_mask[idx];
  - idx == 3: go to DONE;
  - otherwise idx++, counter <= 0, go to SETTLE.
- DONE:
  - o_done = 1 for exactly this cycle;
  - o_pass <= (final mask == 0), with the final SAMPLE compare included;
  - o_busy stays 1 in this cycle and drops on the next; next state IDLE.

Timing:
- Each vector occupies SETTLE_CYCLES+1 cycles.
- The DONE cycle is 4*(SETTLE_CYCLES+1)+1 cycles after the start-accepting edge. Default: 13.
- i_c is sampled only in SAMPLE; glitches during SETTLE are ignored.

Boundary conditions:
- i_start while busy (SETTLE, SAMPLE, DONE): ignored; no restart, no queueing.
- i_start held high continuously: a new test starts on the first IDLE cycle after DONE.
- i_op changes mid-test: ignored, because op_q is latched at start.
- Reset asserted mid-test: immediate return to the reset values; no o_done pulse; o_pass and mask read 0.
- o_pass and o_fail_mask are stable from DONE until the next accepted start.
- In SAMPLE at idx=3, idx must not wrap to 0 before DONE; o_vec_idx holds 3 through DONE and is 0 in IDLE.

Decomposition:
- Shared package gate_tester_pkg:
  - typedef enum op_t: OP_AND=0, OP_OR=1, OP_NOR=2, OP_NAND=3;
  - typedef enum state_t: IDLE, SETTLE, SAMPLE, DONE;
  - localparam NUM_VECTORS=4;
  - function expected(op_t, a, b) returning the golden bit.
- No sub-module. The golden model is a package function, so the bench reuses it.

Test Plan:
- AND gate as DUT, i_op=0, SETTLE_CYCLES=2, start pulse -> o_done at cycle 13, o_pass=1, o_fail_mask=4'b0000, o_a/o_b sequence 00,01,10,11 each held 3 cycles.
- AND gate as DUT, i_op=1 (OR) -> o_pass=0, o_fail_mask=4'b0110.
- NOR gate as DUT, i_op=0 (AND) -> o_fail_mask=4'b1001, o_pass=0; same DUT with i_op=2 -> mask 4'b0000, o_pass=1.
- i_c tied to 1, i_op=3 (NAND) -> o_fail_mask=4'b1000. Also with SETTLE_CYCLES=1: o_done at cycle 9.
- Start re-pulsed at cycles 4 and 12, plus i_op toggled mid-test -> single o_done at cycle 13, result unchanged; i_start held high -> back-to-back tests, o_done every 14 cycles.
- i_rst_n low at cycle 6 for 2 cycles, async relative to i_clk -> outputs 0 immediately, no o_done; a subsequent start runs a full clean test.
